// File: rtl/fma_pipe_arbiter.sv
// Purpose: round-robin sharing of one fixed-latency FMA pipe, results steered to per-requester FIFOs.
// Latency: pipe_in one cycle after grant; response visible LATENCY+2 cycles after grant.
// Backpressure: grant only with a free response credit; the pipe never stalls, results never drop.
module fma_pipe_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int LATENCY   = 4,
  parameter int RSP_DEPTH = 4,
  parameter int PAYLOAD_W = 202
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         issue_en,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
  output logic                         pipe_in_valid,
  output logic [PAYLOAD_W-1:0]         pipe_in_payload,
  input  logic                         pipe_out_valid,
  input  logic [64:0]                  pipe_out_data,
  input  logic [4:0]                   pipe_out_exc,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [NUM_REQ*65-1:0]        rsp_data,
  output logic [NUM_REQ*5-1:0]         rsp_exc,
  output logic                         busy,
  output logic                         err_orphan
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW    = $clog2(RSP_DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0]    CREDIT_MAX = CW'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_ID    = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]     rr_ptr;
  logic [CW-1:0]        credit [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   pop;
  logic [NUM_REQ-1:0]   fifo_wr;
  logic                 grant_any;
  logic [PTR_W-1:0]     grant_id;
  logic [PAYLOAD_W-1:0] payload_sel;
  logic [PTR_W-1:0]     issue_id;
  logic [LATENCY-1:0]   tag_vld;
  logic [PTR_W-1:0]     tag_id [LATENCY];
  logic                 tail_vld;
  logic [PTR_W-1:0]     tail_id;
  logic [69:0]          fifo_mem [NUM_REQ][RSP_DEPTH];
  logic [AW:0]          wr_ptr [NUM_REQ];
  logic [AW:0]          rd_ptr [NUM_REQ];

  assign tail_vld = tag_vld[LATENCY-1];
  assign tail_id  = tag_id[LATENCY-1];

  // Eligibility uses the registered credit, so a same-cycle pop cannot unblock a grant.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = reset & issue_en & req_valid[i] & (credit[i] < CREDIT_MAX);
    end
  end

  // Round-robin pick: first eligible index at or above rr_ptr, then wrap to the low indices.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    grant     = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_any && eligible[j] && (PTR_W'(j) >= rr_ptr)) begin
        grant_any = 1'b1;
        grant_id  = PTR_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_any && eligible[j] && (PTR_W'(j) < rr_ptr)) begin
        grant_any = 1'b1;
        grant_id  = PTR_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      grant[j] = grant_any && (grant_id == PTR_W'(j));
    end
  end

  assign req_ready = grant;

  // Operand mux for the winning requester.
  always_comb begin
    payload_sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_id == PTR_W'(j)) payload_sel = req_payload[j*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  // Tail of the tag line writes into the owner's FIFO only when the pipe agrees.
  always_comb begin
    fifo_wr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      fifo_wr[i] = tail_vld & pipe_out_valid & (tail_id == PTR_W'(i));
    end
  end

  // Issue register, round-robin pointer, ownership tag line and sticky orphan flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr          <= '0;
      pipe_in_valid   <= 1'b0;
      pipe_in_payload <= '0;
      issue_id        <= '0;
      tag_vld         <= '0;
      for (int s = 0; s < LATENCY; s++) tag_id[s] <= '0;
      err_orphan      <= 1'b0;
    end else begin
      pipe_in_valid <= grant_any;
      if (grant_any) begin
        rr_ptr          <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        pipe_in_payload <= payload_sel;
        issue_id        <= grant_id;
      end
      // Stage 0 follows the issue register, so the tail lines up with pipe_out_valid.
      tag_vld[0] <= pipe_in_valid;
      tag_id[0]  <= issue_id;
      for (int s = 1; s < LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
      if (tail_vld != pipe_out_valid) err_orphan <= 1'b1;
    end
  end

  // Credits count in-flight plus buffered results; FIFO pointers advance on write/pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        credit[i] <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fifo_wr[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (grant[i] && !pop[i])      credit[i] <= credit[i] + 1'b1;
        else if (!grant[i] && pop[i]) credit[i] <= credit[i] - 1'b1;
      end
    end
  end

  // Response storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fifo_wr[i]) fifo_mem[i][wr_ptr[i][AW-1:0]] <= {pipe_out_exc, pipe_out_data};
    end
  end

  // Head-of-FIFO outputs (zeroed when empty) and the busy summary.
  always_comb begin
    rsp_valid = '0;
    pop       = '0;
    rsp_data  = '0;
    rsp_exc   = '0;
    busy      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (wr_ptr[i] != rd_ptr[i]);
      pop[i]       = rsp_valid[i] & rsp_ready[i];
      if (rsp_valid[i]) begin
        rsp_data[i*65 +: 65] = fifo_mem[i][rd_ptr[i][AW-1:0]][64:0];
        rsp_exc[i*5 +: 5]    = fifo_mem[i][rd_ptr[i][AW-1:0]][69:65];
      end
      if (credit[i] != '0) busy = 1'b1;
    end
  end
endmodule

// File: tb/tb_fma_pipe_arbiter.sv
// Purpose: directed bench for fma_pipe_arbiter with a queue-based reference model and a stand-in FMA pipe.
// Latency: the stand-in pipe returns each issued op LATENCY cycles after pipe_in_valid.
// Backpressure: rsp_ready patterns are driven per test to exercise credit stalls.
module tb_fma_pipe_arbiter;
  localparam int NREQ  = 2;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;
  localparam int PW    = 202;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              issue_en = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*PW-1:0] req_payload = '0;
  logic              pipe_in_valid;
  logic [PW-1:0]     pipe_in_payload;
  logic              pipe_out_valid = 1'b0;
  logic [64:0]       pipe_out_data = '0;
  logic [4:0]        pipe_out_exc = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [NREQ*65-1:0] rsp_data;
  logic [NREQ*5-1:0] rsp_exc;
  logic              busy;
  logic              err_orphan;
  logic              inject = 1'b0;

  int checks = 0;
  int failures = 0;

  fma_pipe_arbiter #(.NUM_REQ(NREQ), .LATENCY(LAT), .RSP_DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clock(clock), .reset(reset), .issue_en(issue_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_payload(req_payload),
    .pipe_in_valid(pipe_in_valid), .pipe_in_payload(pipe_in_payload),
    .pipe_out_valid(pipe_out_valid), .pipe_out_data(pipe_out_data), .pipe_out_exc(pipe_out_exc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_exc(rsp_exc),
    .busy(busy), .err_orphan(err_orphan)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Stand-in FMA: result = in1^in2^in3, flags = {rm, fmaCmd}.
  function automatic logic [64:0] fnd(input logic [PW-1:0] p);
    return p[194:130] ^ p[129:65] ^ p[64:0];
  endfunction
  function automatic logic [4:0] fne(input logic [PW-1:0] p);
    return p[199:195];
  endfunction
  function automatic logic [PW-1:0] mkpay(input logic [2:0] rm, input logic [1:0] cmd,
                                          input logic [64:0] a, input logic [64:0] b, input logic [64:0] c);
    return {1'b0, 1'b0, rm, cmd, a, b, c};
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int          id;
    int          due;
    logic [64:0] d;
    logic [4:0]  e;
  } ent_t;

  int          cyc = 0;
  int          m_rr = 0;
  int          m_credit [NREQ];
  logic        m_err = 1'b0;
  logic        m_piv = 1'b0;
  logic [PW-1:0] m_pip = '0;
  ent_t        inflight [$];
  ent_t        rspq [$];

  function automatic int mgrant();
    int idx;
    if (!reset || !issue_en) return -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_rr + k) % NREQ;
      if (req_valid[idx] && m_credit[idx] < DEPTH) return idx;
    end
    return -1;
  endfunction

  // Index of requester i's oldest response if it is visible this cycle, else -1.
  function automatic int first_idx(input int i);
    for (int j = 0; j < rspq.size(); j++) begin
      if (rspq[j].id == i) return (rspq[j].due <= cyc) ? j : -1;
    end
    return -1;
  endfunction

  // Model update at each rising edge.
  always @(posedge clock) begin
    int g;
    int j;
    ent_t e;
    if (!reset) begin
      m_rr = 0;
      for (int i = 0; i < NREQ; i++) m_credit[i] = 0;
      m_err = 1'b0;
      m_piv = 1'b0;
      m_pip = '0;
      inflight.delete();
      rspq.delete();
    end else begin
      g = mgrant();
      for (int i = 0; i < NREQ; i++) begin
        j = first_idx(i);
        if (j >= 0 && rsp_ready[i]) begin
          rspq.delete(j);
          m_credit[i]--;
        end
      end
      if (inflight.size() > 0 && inflight[0].due == cyc) begin
        e = inflight.pop_front();
        if (pipe_out_valid) begin
          e.due = cyc + 1;
          rspq.push_back(e);
        end else m_err = 1'b1;
      end else if (pipe_out_valid) m_err = 1'b1;
      if (g >= 0) begin
        e.id  = g;
        e.due = cyc + 1 + LAT;
        e.d   = fnd(req_payload[g*PW +: PW]);
        e.e   = fne(req_payload[g*PW +: PW]);
        inflight.push_back(e);
        m_credit[g]++;
        m_rr  = (g + 1) % NREQ;
        m_piv = 1'b1;
        m_pip = req_payload[g*PW +: PW];
      end else m_piv = 1'b0;
    end
    cyc++;
  end

  // Stand-in pipe delay line.
  bit          env_v [LAT];
  logic [PW-1:0] env_p [LAT];

  // Per-cycle comparison against the model, then advance the stand-in pipe.
  always @(negedge clock) begin
    int g;
    int j;
    logic [NREQ-1:0] exp_rdy;
    logic any_credit;
    if (!reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_pipe_in_valid", pipe_in_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_orphan", err_orphan, 0);
    end else begin
      g = mgrant();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      any_credit = 1'b0;
      for (int i = 0; i < NREQ; i++) if (m_credit[i] != 0) any_credit = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("pipe_in_valid", pipe_in_valid, m_piv);
      chk("pipe_in_payload", pipe_in_payload, m_pip);
      chk("busy", busy, any_credit);
      chk("err_orphan", err_orphan, m_err);
      for (int i = 0; i < NREQ; i++) begin
        j = first_idx(i);
        chk("rsp_valid", rsp_valid[i], j >= 0);
        if (j >= 0) begin
          chk("rsp_data", rsp_data[i*65 +: 65], rspq[j].d);
          chk("rsp_exc", rsp_exc[i*5 +: 5], rspq[j].e);
        end
      end
    end
    pipe_out_valid = env_v[LAT-1] | inject;
    pipe_out_data  = env_v[LAT-1] ? fnd(env_p[LAT-1]) : 65'h1abc;
    pipe_out_exc   = env_v[LAT-1] ? fne(env_p[LAT-1]) : 5'h1f;
    for (int s = LAT-1; s > 0; s--) begin
      env_v[s] = env_v[s-1];
      env_p[s] = env_p[s-1];
    end
    env_v[0] = pipe_in_valid;
    env_p[0] = pipe_in_payload;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic sample();
    @(negedge clock);
  endtask
  task automatic set_pay(input int i, input logic [PW-1:0] p);
    req_payload[i*PW +: PW] = p;
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    logic [PW-1:0] p1;
    logic [NREQ-1:0] gr [8];
    int c0, c1, alt, pops;
    #3 reset = 1'b0;
    repeat (3) @(posedge clock);
    sample();
    chk("reset_pipe_payload", pipe_in_payload, 0);
    chk("reset_rsp_data", rsp_data, 0);
    step();
    reset = 1'b1;

    // Single op: response visible 6 cycles after grant.
    p1 = mkpay(3'b101, 2'b10, 65'h3, 65'h5, 65'h10);
    step(); issue_en = 1'b1; rsp_ready = 2'b11; req_valid = 2'b01; set_pay(0, p1);
    sample(); chk("t1_grant", req_ready, 2'b01);
    for (int k = 1; k <= 7; k++) begin
      step(); req_valid = '0;
      sample();
      if (k == 1) begin
        chk("t1_pipe_in_valid", pipe_in_valid, 1);
        chk("t1_pipe_in_payload", pipe_in_payload, p1);
      end
      if (k == 5) chk("t1_rsp_not_yet", rsp_valid, 2'b00);
      if (k == 6) begin
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_data", rsp_data[64:0], 65'h16);
        chk("t1_rsp_exc", rsp_exc[4:0], 5'h16);
        chk("t1_busy_before_pop", busy, 1);
      end
      if (k == 7) begin
        chk("t1_busy_after_pop", busy, 0);
        chk("t1_rsp_empty", rsp_valid, 2'b00);
      end
    end

    // Fairness: both requesting for 8 cycles.
    c0 = 0; c1 = 0; alt = 0;
    for (int k = 0; k < 8; k++) begin
      step(); req_valid = 2'b11;
      set_pay(0, mkpay(3'd1, 2'd0, 65'(k), 65'h100, 65'h7));
      set_pay(1, mkpay(3'd2, 2'd1, 65'h55, 65'(k * 3), 65'h9));
      sample();
      gr[k] = req_ready;
      if (req_ready[0]) c0++;
      if (req_ready[1]) c1++;
      if (k > 0 && gr[k] != gr[k-1]) alt++;
    end
    chk("t2_first_grant", gr[0], 2'b10);
    chk("t2_grants_req0", c0, 4);
    chk("t2_grants_req1", c1, 4);
    chk("t2_alternations", alt, 7);
    step(); req_valid = '0;
    repeat (10) step();
    sample(); chk("t2_drained", busy, 0);

    // Credit stall on requester 0.
    c0 = 0;
    step(); rsp_ready = 2'b10; req_valid = 2'b01;
    for (int k = 0; k < 10; k++) begin
      set_pay(0, mkpay(3'd3, 2'd2, 65'(k + 40), 65'h1, 65'h2));
      sample();
      if (req_ready[0]) c0++;
      step();
    end
    chk("t3_grants_until_full", c0, 4);
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      sample(); chk("t3_other_still_granted", req_ready, 2'b10);
      step();
    end
    req_valid = 2'b01;
    c0 = 0;
    for (int k = 0; k < 10; k++) begin
      sample(); if (req_ready != 0) c0++;
      step();
    end
    chk("t3_blocked", c0, 0);
    rsp_ready = 2'b11;
    sample();
    chk("t3_pop_same_cycle_no_grant", req_ready, 2'b00);
    chk("t3_pop_head_valid", rsp_valid[0], 1);
    step(); rsp_ready = 2'b10;
    sample(); chk("t3_grant_after_pop", req_ready, 2'b01);
    c0 = 0;
    for (int k = 0; k < 4; k++) begin
      step(); sample();
      if (req_ready != 0) c0++;
    end
    chk("t3_only_one_more", c0, 0);
    step(); rsp_ready = 2'b11; req_valid = '0;
    repeat (14) step();
    sample(); chk("t3_drained", busy, 0);

    // Quiesce with three ops in flight.
    c0 = 0;
    step(); req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      set_pay(0, mkpay(3'd4, 2'd3, 65'(k + 7), 65'h3c, 65'h11));
      sample(); if (req_ready[0]) c0++;
      step();
    end
    chk("t4_three_issued", c0, 3);
    issue_en = 1'b0; req_valid = 2'b11;
    c1 = 0; pops = 0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (k == 0) chk("t4_busy_while_quiesced", busy, 1);
      if (req_ready != 0) c1++;
      if (rsp_valid[0] && rsp_ready[0]) pops++;
      step();
    end
    chk("t4_no_grants", c1, 0);
    chk("t4_all_responses", pops, 3);
    sample(); chk("t4_busy_fell", busy, 0);
    step(); issue_en = 1'b1; req_valid = '0;

    // Orphan result with an empty tag line.
    step(); inject = 1'b1;
    sample(); chk("t5_err_before", err_orphan, 0);
    step(); inject = 1'b0;
    sample();
    chk("t5_err_set", err_orphan, 1);
    chk("t5_no_write", rsp_valid, 2'b00);
    repeat (3) step();
    sample(); chk("t5_err_sticky", err_orphan, 1);

    // Asynchronous reset with two ops in flight.
    step(); req_valid = 2'b01; set_pay(0, mkpay(3'd0, 2'd1, 65'h21, 65'h22, 65'h23));
    step(); set_pay(0, mkpay(3'd0, 2'd1, 65'h31, 65'h32, 65'h33));
    step(); req_valid = '0;
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_pipe_in_valid", pipe_in_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rsp_valid_now", rsp_valid, 2'b00);
    chk("t6_pipe_in_valid_now", pipe_in_valid, 0);
    chk("t6_busy_now", busy, 0);
    step(); reset = 1'b1; req_valid = 2'b11;
    sample(); chk("t6_first_grant_req0", req_ready, 2'b01);
    step(); req_valid = '0;
    repeat (12) step();
    sample();
    chk("t6_orphan_after_release", err_orphan, 1);
    chk("t6_drained", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the scenario sequence ever fails to complete.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
